// File: rtl/restoring_divider.sv
// Unsigned restoring divider: one quotient bit per clock.
// Divide-by-zero finishes at once with all-ones quotient.
module restoring_divider #(
   parameter int n = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [n-1:0] dividend,
   input  logic [n-1:0] divisor,
   output logic         busy,
   output logic         done,
   output logic [n-1:0] quotient,
   output logic [n-1:0] remainder,
   output logic         div_by_zero
);

   localparam int cw = $clog2(n) + 1;
   localparam logic [cw-1:0] last = cw'(n - 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]    state;
   logic [n:0]    r;
   logic [n-1:0]  q;
   logic [n-1:0]  d;
   logic [cw-1:0] cnt;

   logic [n:0]    shifted;
   logic [n:0]    trial;
   logic [n:0]    r_nxt;
   logic [n-1:0]  q_nxt;

   // R stays below the divisor, so its top bit is always
   // zero and simply falls out of the left shift.
   logic unused_r_msb;
   assign unused_r_msb = r[n];

   assign busy = (state == RUN);
   assign done = (state == DONE);

   // One shift/subtract step; restore is a plain 2:1 select.
   always_comb begin
      shifted = {r[n-1:0], q[n-1]};
      trial   = shifted - {1'b0, d};
      r_nxt   = shifted;
      q_nxt   = {q[n-2:0], 1'b0};
      if (!trial[n]) begin
         r_nxt = trial;
         q_nxt = {q[n-2:0], 1'b1};
      end
   end

   // Control FSM, datapath registers and held results.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         r           <= '0;
         q           <= '0;
         d           <= '0;
         cnt         <= '0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  if (divisor == '0) begin
                     quotient    <= '1;
                     remainder   <= dividend;
                     div_by_zero <= 1'b1;
                     state       <= DONE;
                  end else begin
                     d     <= divisor;
                     q     <= dividend;
                     r     <= '0;
                     cnt   <= '0;
                     state <= RUN;
                  end
               end
            end
            RUN: begin
               r   <= r_nxt;
               q   <= q_nxt;
               cnt <= cnt + 1'b1;
               if (cnt == last) begin
                  quotient    <= q_nxt;
                  remainder   <= r_nxt[n-1:0];
                  div_by_zero <= 1'b0;
                  state       <= DONE;
               end
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_restoring_divider.sv
// Directed and random checks of restoring_divider
// against a queue of expected results.
module tb_restoring_divider;

   localparam int N = 16;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [N-1:0] dividend;
   logic [N-1:0] divisor;
   logic         busy;
   logic         done;
   logic [N-1:0] quotient;
   logic [N-1:0] remainder;
   logic         div_by_zero;

   typedef struct {
      logic [N-1:0] q;
      logic [N-1:0] r;
      logic         z;
   } exp_t;

   exp_t sb[$];
   int   n_vec = 0;
   int   n_err = 0;

   restoring_divider #(.n(N)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [63:0] obs,
                      input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h",
                tag, obs, exp);
      end
   endtask

   task automatic push(input logic [N-1:0] a,
                       input logic [N-1:0] b);
      exp_t e;
      if (b == '0) begin
         e.q = '1;
         e.r = a;
         e.z = 1'b1;
      end else begin
         e.q = a / b;
         e.r = a % b;
         e.z = 1'b0;
      end
      sb.push_back(e);
   endtask

   // Issue one division; optionally pulse a stray start
   // with other operands at RUN cycle ign_at.
   task automatic op(input logic [N-1:0] a,
                     input logic [N-1:0] b,
                     input int           ign_at,
                     input logic [N-1:0] ia,
                     input logic [N-1:0] ib);
      exp_t         e;
      int           bc;
      int           t;
      logic [N-1:0] hq;
      logic [N-1:0] hr;
      logic         hz;
      logic         moved;
      push(a, b);
      @(posedge clk);
      #1;
      hq       = quotient;
      hr       = remainder;
      hz       = div_by_zero;
      moved    = 1'b0;
      start    = 1'b1;
      dividend = a;
      divisor  = b;
      @(negedge clk);
      chk("idle_before_start", {busy, done}, 2'b00);
      @(posedge clk);
      #1;
      start    = 1'b0;
      dividend = ~a;
      divisor  = b ^ 16'h5a5a;
      bc = 0;
      t  = 0;
      while (t < 40) begin
         @(negedge clk);
         t++;
         if (done) break;
         if (busy) bc++;
         if ({quotient, remainder, div_by_zero} !==
             {hq, hr, hz})
            moved = 1'b1;
         if (ign_at > 0 && bc == ign_at) begin
            start    = 1'b1;
            dividend = ia;
            divisor  = ib;
         end else begin
            start = 1'b0;
         end
      end
      start = 1'b0;
      chk("done_seen", done, 1'b1);
      e = sb.pop_front();
      if (done) begin
         chk("quotient", quotient, e.q);
         chk("remainder", remainder, e.r);
         chk("div_by_zero", div_by_zero, e.z);
         chk("busy_cycles", bc, (b == '0) ? 0 : N);
         chk("busy_at_done", busy, 1'b0);
         chk("held_during_run", moved, 1'b0);
         if (b != '0) begin
            chk("q*d+r",
                64'(quotient) * 64'(b) + 64'(remainder),
                64'(a));
            chk("r_lt_d", remainder < b, 1'b1);
         end
      end
   endtask

   initial begin
      int ndone;
      logic [N-1:0] ra;
      logic [N-1:0] rb;

      rst      = 1'b1;
      start    = 1'b0;
      dividend = '0;
      divisor  = '0;
      repeat (2) @(negedge clk);
      chk("reset_busy", busy, 1'b0);
      chk("reset_done", done, 1'b0);
      chk("reset_q", quotient, 16'h0000);
      chk("reset_r", remainder, 16'h0000);
      chk("reset_dbz", div_by_zero, 1'b0);
      rst = 1'b0;

      op(16'd100, 16'd7, 0, '0, '0);
      op(16'hffff, 16'h0001, 0, '0, '0);
      op(16'd5, 16'd9, 0, '0, '0);
      op(16'h1234, 16'h0000, 0, '0, '0);
      op(16'd100, 16'd7, 5, 16'd9, 16'd3);

      repeat (4) @(negedge clk);
      chk("held_done", done, 1'b0);
      chk("held_q", quotient, 16'd14);
      chk("held_r", remainder, 16'd2);

      @(posedge clk);
      #1;
      start    = 1'b1;
      dividend = 16'd100;
      divisor  = 16'd7;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (8) @(negedge clk);
      chk("mid_run_busy", busy, 1'b1);
      #1;
      rst = 1'b1;
      #1;
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_q", quotient, 16'h0000);
      chk("rst_r", remainder, 16'h0000);
      chk("rst_dbz", div_by_zero, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      ndone = 0;
      repeat (20) begin
         @(negedge clk);
         if (done) ndone++;
      end
      chk("no_done_after_abort", ndone, 0);

      op(16'hffff, 16'hffff, 0, '0, '0);

      for (int i = 0; i < 20; i++) begin
         ra = 16'($urandom);
         rb = 16'($urandom_range(1, 16'hffff));
         if (i % 4 == 0) rb = 16'($urandom_range(1, 15));
         op(ra, rb, 0, '0, '0);
      end

      $display("== %0d vectors applied, %0d miscompares ==",
               n_vec, n_err);
      $finish;
   end

endmodule
